// File: rtl/oled_spi_arbiter.sv
// Two-requester arbiter (C = command sequencer, P = pixel streamer) feeding one
// SPI byte transmitter. Whole bursts are granted round-robin, with a DC-safe gap after every byte.
module oled_spi_arbiter #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 4095
) (
  input  logic              clk_50M,
  input  logic              rst_n,
  input  logic              c_valid,
  input  logic [DATA_W-1:0] c_data,
  input  logic              c_dc,
  input  logic              c_last,
  output logic              c_ready,
  input  logic              p_valid,
  input  logic [DATA_W-1:0] p_data,
  input  logic              p_dc,
  input  logic              p_last,
  output logic              p_ready,
  output logic              spi_wr,
  output logic [DATA_W-1:0] spi_data,
  output logic              spi_dc,
  input  logic              spi_done,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              timeout_err,
  input  logic              clr_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WR, S_WAIT, S_GAP} state_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              dc;
    logic              last;
  } req_t;

  state_t            state, state_nx;
  logic [1:0]        grant_nx;
  logic              last_served, last_served_nx;  // 0 = C, 1 = P
  logic [TW-1:0]     timer, timer_nx;
  logic [GW-1:0]     gap_cnt, gap_nx;
  logic [DATA_W-1:0] data_nx;
  logic              dc_nx, last_r, last_nx, err_nx;
  req_t              c_req, p_req, own;

  assign c_req = '{valid: c_valid, data: c_data, dc: c_dc, last: c_last};
  assign p_req = '{valid: p_valid, data: p_data, dc: p_dc, last: p_last};
  assign own   = grant[1] ? p_req : c_req;

  // Ready is decoded from the registered grant, so only the owner can ever see it.
  assign c_ready = (state == S_LOAD) && grant[0];
  assign p_ready = (state == S_LOAD) && grant[1];
  assign spi_wr  = (state == S_WR);
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      grant       <= 2'b00;
      last_served <= 1'b1;
      timer       <= '0;
      gap_cnt     <= '0;
      spi_data    <= '0;
      spi_dc      <= 1'b0;
      last_r      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      grant       <= grant_nx;
      last_served <= last_served_nx;
      timer       <= timer_nx;
      gap_cnt     <= gap_nx;
      spi_data    <= data_nx;
      spi_dc      <= dc_nx;
      last_r      <= last_nx;
      timeout_err <= err_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    grant_nx       = grant;
    last_served_nx = last_served;
    timer_nx       = timer;
    gap_nx         = gap_cnt;
    data_nx        = spi_data;
    dc_nx          = spi_dc;
    last_nx        = last_r;
    err_nx         = timeout_err & ~clr_err;  // a timeout below overrides the clear
    case (state)
      S_IDLE: begin
        if (c_valid && (!p_valid || last_served)) begin
          grant_nx = 2'b01;
          state_nx = S_LOAD;
        end else if (p_valid) begin
          grant_nx = 2'b10;
          state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        if (own.valid) begin
          data_nx  = own.data;
          dc_nx    = own.dc;
          last_nx  = own.last;
          state_nx = S_WR;
        end
      end
      S_WR: begin
        timer_nx = '0;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (spi_done) begin
          gap_nx   = '0;
          state_nx = S_GAP;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          err_nx         = 1'b1;
          grant_nx       = 2'b00;
          last_served_nx = grant[1];
          state_nx       = S_IDLE;
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
          if (last_r) begin
            grant_nx       = 2'b00;
            last_served_nx = grant[1];
            state_nx       = S_IDLE;
          end else begin
            state_nx = S_LOAD;
          end
        end else begin
          gap_nx = gap_cnt + GW'(1);
        end
      end
      default: begin
        grant_nx = 2'b00;
        state_nx = S_IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_oled_spi_arbiter.sv
// Bench for oled_spi_arbiter: a per-cycle timeline model of grants and byte
// timing, directed scenarios with literal expectations, then randomized traffic.
module tb_oled_spi_arbiter;
  localparam int DW = 8;
  localparam int GAP = 4;
  localparam int TO = 30;

  logic clk_50M = 1'b0, rst_n = 1'b0;
  logic c_valid = 0, c_dc = 0, c_last = 0, p_valid = 0, p_dc = 0, p_last = 0;
  logic [DW-1:0] c_data = '0, p_data = '0;
  logic spi_done = 0, clr_err = 0;
  logic c_ready, p_ready, spi_wr, spi_dc, busy, timeout_err;
  logic [DW-1:0] spi_data;
  logic [1:0] grant;

  oled_spi_arbiter #(.DATA_W(DW), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clk_50M(clk_50M), .rst_n(rst_n),
    .c_valid(c_valid), .c_data(c_data), .c_dc(c_dc), .c_last(c_last), .c_ready(c_ready),
    .p_valid(p_valid), .p_data(p_data), .p_dc(p_dc), .p_last(p_last), .p_ready(p_ready),
    .spi_wr(spi_wr), .spi_data(spi_data), .spi_dc(spi_dc), .spi_done(spi_done),
    .grant(grant), .busy(busy), .timeout_err(timeout_err), .clr_err(clr_err));

  always #5 clk_50M = ~clk_50M;

  typedef struct {logic [DW-1:0] d; logic dc; logic last;} byte_t;
  byte_t cq[$], pq[$];

  int checks = 0, errors = 0;
  int cyc = 0;
  // timeline model: owner (-1 none, 0 C, 1 P), window open cycle, wr cycle, release cycle
  int mo = -1, wopen = 0, wr_at = -1, rel_at = -1;
  bit ls = 1, infl = 0, merr = 0, mdc = 0, mlast = 0;
  logic [DW-1:0] mdata = '0;
  // observation logs (drive stimulus and literal checks)
  int wcyc[$];
  logic [DW-1:0] wdq[$];
  logic wdc[$];
  logic [1:0] wgr[$];
  int last_wr = -100, err_cyc = -1;
  bit acc_c = 0, acc_p = 0, prev_err = 0, last_cready = 0;
  logic [1:0] last_grant = 2'b00;
  bit rand_mode = 0;
  int done_mode = 1, dprob = 6;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic eval();
    logic [15:0] act_v, exp_v;
    logic [1:0] eg;
    bit open, ov;
    act_v = {grant, c_ready, p_ready, spi_wr, busy, timeout_err, spi_dc, spi_data};
    last_grant = grant;
    last_cready = c_ready;
    if (spi_wr) begin
      wcyc.push_back(cyc); wdq.push_back(spi_data); wdc.push_back(spi_dc); wgr.push_back(grant);
      last_wr = cyc;
    end
    if (timeout_err && !prev_err) err_cyc = cyc;
    prev_err = timeout_err;
    if (!rst_n) begin
      mo = -1; ls = 1; infl = 0; rel_at = -1; merr = 0; mdata = '0; mdc = 0; mlast = 0;
      wopen = 0; wr_at = -1;
      chk("reset_outputs", act_v, 16'h0);
      acc_c = 0; acc_p = 0;
      cyc++;
      return;
    end
    if (rel_at == cyc) begin ls = (mo == 1); mo = -1; rel_at = -1; end
    eg = (mo == 0) ? 2'b01 : (mo == 1) ? 2'b10 : 2'b00;
    open = (mo >= 0) && !infl && (rel_at < 0) && (cyc >= wopen);
    exp_v = {eg, open && mo == 0, open && mo == 1, infl && cyc == wr_at, mo >= 0, merr, mdc, mdata};
    chk("cycle_outputs", act_v, exp_v);
    acc_c = c_valid && c_ready;
    acc_p = p_valid && p_ready;
    // advance the model with this cycle's inputs
    if (mo < 0) begin
      if (c_valid && (!p_valid || ls)) begin mo = 0; wopen = cyc + 1; end
      else if (p_valid) begin mo = 1; wopen = cyc + 1; end
      if (clr_err) merr = 0;
    end else begin
      ov = (mo == 0) ? c_valid : p_valid;
      if (clr_err) merr = 0;
      if (rel_at < 0) begin
        if (open) begin
          if (ov) begin
            mdata = (mo == 0) ? c_data : p_data;
            mdc   = (mo == 0) ? c_dc : p_dc;
            mlast = (mo == 0) ? c_last : p_last;
            infl = 1; wr_at = cyc + 1;
          end
        end else if (infl && cyc > wr_at) begin
          if (spi_done) begin
            infl = 0;
            if (mlast) rel_at = cyc + GAP + 1;
            else wopen = cyc + GAP + 1;
          end else if (cyc == wr_at + TO) begin
            merr = 1; infl = 0; rel_at = cyc + 1;
          end
        end
      end
    end
    cyc++;
  endtask

  task automatic tick();
    byte_t t;
    if (rand_mode) begin
      c_valid = ($urandom_range(0, 3) != 0); c_data = DW'($urandom);
      c_dc = 1'($urandom); c_last = ($urandom_range(0, 2) == 0);
      p_valid = ($urandom_range(0, 2) != 0); p_data = DW'($urandom);
      p_dc = 1'($urandom); p_last = ($urandom_range(0, 3) == 0);
      spi_done = ($urandom_range(0, dprob) == 0);
      clr_err = ($urandom_range(0, 80) == 0);
    end else begin
      if (acc_c && cq.size() > 0) t = cq.pop_front();
      if (acc_p && pq.size() > 0) t = pq.pop_front();
      c_valid = (cq.size() > 0);
      if (c_valid) begin c_data = cq[0].d; c_dc = cq[0].dc; c_last = cq[0].last; end
      p_valid = (pq.size() > 0);
      if (p_valid) begin p_data = pq[0].d; p_dc = pq[0].dc; p_last = pq[0].last; end
      if (done_mode == 1) spi_done = (cyc == last_wr + 8);
      else if (done_mode == 2) spi_done = 0;
    end
    @(negedge clk_50M);
    eval();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_logs();
    wcyc.delete(); wdq.delete(); wdc.delete(); wgr.delete();
  endtask

  function automatic byte_t mk(input logic [DW-1:0] d, input logic dc, input logic last);
    byte_t b;
    b.d = d; b.dc = dc; b.last = last;
    return b;
  endfunction

  initial begin
    int t0, bad, n0;
    rst_n = 0;
    run(3);
    rst_n = 1;
    run(2);

    // C burst 0xAE, 0xD5 (commands), done 8 cycles after each wr
    clear_logs();
    t0 = cyc;
    cq.push_back(mk(8'hAE, 0, 0)); cq.push_back(mk(8'hD5, 0, 1));
    run(40);
    chk("d1_wr_count", wcyc.size(), 2);
    if (wcyc.size() == 2) begin
      chk("d1_first_wr_latency", wcyc[0] - t0, 2);
      chk("d1_data0", wdq[0], 8'hAE);
      chk("d1_data1", wdq[1], 8'hD5);
      chk("d1_dc", {wdc[0], wdc[1]}, 2'b00);
      chk("d1_wr_spacing", wcyc[1] - wcyc[0], 8 + GAP + 2);
      chk("d1_grant_at_wr", wgr[0], 2'b01);
    end
    chk("d1_grant_end", {last_grant, busy}, 3'b000);

    // simultaneous C and P after reset: C first, P burst after C's last byte
    rst_n = 0; run(2); rst_n = 1; run(2);
    clear_logs();
    cq.push_back(mk(8'h3C, 0, 1));
    pq.push_back(mk(8'h01, 1, 0)); pq.push_back(mk(8'h02, 1, 0)); pq.push_back(mk(8'h03, 1, 1));
    run(2);
    chk("d2_tie_grant", last_grant, 2'b01);
    run(70);
    chk("d2_wr_count", wdq.size(), 4);
    if (wdq.size() == 4) chk("d2_order", {wdq[0], wdq[1], wdq[2], wdq[3]}, 32'h3C010203);
    cq.push_back(mk(8'h77, 0, 1)); pq.push_back(mk(8'h88, 1, 1));
    run(2);
    chk("d2_second_tie_grant", last_grant, 2'b01);
    run(40);

    // P stalls mid-burst in LOAD while C waits
    clear_logs();
    pq.push_back(mk(8'hA1, 1, 0));
    run(25);
    cq.push_back(mk(8'h55, 0, 1));
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (last_grant != 2'b10 || last_cready) bad++;
    end
    chk("d3_lock_held", bad, 0);
    pq.push_back(mk(8'hA2, 1, 1));
    run(45);
    chk("d3_wr_count", wdq.size(), 3);
    if (wdq.size() == 3) chk("d3_order", {wdq[0], wdq[1], wdq[2]}, 24'hA1A255);

    // spi_done never returns -> timeout
    clear_logs();
    done_mode = 2; err_cyc = -1;
    cq.push_back(mk(8'h11, 0, 1));
    run(TO + 12);
    chk("d4_err_grant_busy", {timeout_err, grant, busy}, 4'b1000);
    if (wcyc.size() > 0) chk("d4_timeout_cycle", err_cyc - wcyc[0], TO + 1);
    clr_err = 1; tick(); clr_err = 0; tick();
    chk("d4_err_cleared", timeout_err, 1'b0);
    done_mode = 1;
    cq.push_back(mk(8'h22, 1, 1));
    run(30);
    chk("d4_recover_wr_count", wdq.size(), 2);
    if (wdq.size() == 2) chk("d4_recover_data", {wdq[1], wdc[1]}, 9'h045);

    // reset asserted while in WAIT, spurious done afterwards
    done_mode = 2;
    n0 = wcyc.size();
    cq.push_back(mk(8'h33, 0, 0)); cq.push_back(mk(8'h44, 0, 1));
    for (int i = 0; i < 20 && wcyc.size() == n0; i++) tick();
    run(2);
    rst_n = 0;
    tick();
    chk("d5_reset_outputs", {grant, busy, spi_data, spi_dc, c_ready}, 13'h0);
    cq.delete(); pq.delete();
    tick();
    rst_n = 1;
    done_mode = 3; spi_done = 1; tick(); spi_done = 0;
    n0 = wcyc.size();
    run(20);
    chk("d5_no_wr_after_reset", wcyc.size(), n0);
    chk("d5_idle", {grant, busy}, 3'b000);

    // mixed dc per byte
    done_mode = 1;
    clear_logs();
    cq.push_back(mk(8'h10, 0, 0)); cq.push_back(mk(8'h11, 1, 0)); cq.push_back(mk(8'h12, 1, 1));
    run(60);
    chk("d6_wr_count", wdc.size(), 3);
    if (wdc.size() == 3) chk("d6_dc_seq", {wdc[0], wdc[1], wdc[2]}, 3'b011);

    // randomized traffic against the model
    rand_mode = 1; dprob = 6;
    for (int i = 0; i < 6000; i++) begin
      if (i == 3000) rst_n = 0;
      if (i == 3002) rst_n = 1;
      tick();
    end
    dprob = 50;
    run(2000);
    rand_mode = 0;
    c_valid = 0; p_valid = 0; spi_done = 0; clr_err = 0;
    cq.delete(); pq.delete();
    run(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
